// File: rtl/reg_bank_rw_pkg.sv
// reg_bank_rw_pkg: shared widths, register indices and types for the register bank
package reg_bank_rw_pkg;
    localparam int DATA_BITS    = 32;
    localparam int IDX_BITS     = 5;
    localparam int REG_ZERO     = 0;
    localparam int REG_SP       = 29;
    localparam int REG_RA       = 31;
    localparam int SP_RESET_VAL = 227;
    typedef logic [IDX_BITS-1:0]  reg_idx_t;
    typedef logic [DATA_BITS-1:0] word_t;
endpackage

// File: rtl/reg_bank_read_port.sv
// reg_bank_read_port: zero-register check, write bypass and array select for one read port
import reg_bank_rw_pkg::*;
module reg_bank_read_port #(
    parameter int DATA_W = DATA_BITS,
    parameter int ADDR_W = IDX_BITS
) (
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] read_reg,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);
    always_comb
        read_data = (read_reg == ADDR_W'(REG_ZERO)) ? '0 :
                    (reg_write && write_reg == read_reg) ? write_data : regs[read_reg];
endmodule

// File: rtl/reg_bank_rw.sv
// reg_bank_rw: 32x32 register bank with sync reset, two bypassed async read ports
import reg_bank_rw_pkg::*;
module reg_bank_rw #(
    parameter int DATA_W   = DATA_BITS,
    parameter int ADDR_W   = IDX_BITS,
    parameter int SP_IDX   = REG_SP,
    parameter int SP_RESET = SP_RESET_VAL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              write_done
);
    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic              commit;
    assign commit = reg_write && write_reg != ADDR_W'(REG_ZERO);
    // reg[0] is never written, so it holds its reset value of zero forever
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++)
                regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            write_done <= 1'b0;
        end else begin
            if (commit)
                regs[write_reg] <= write_data;
            write_done <= commit;
        end
    end
    reg_bank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
        .regs(regs), .read_reg(read_reg1), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data), .read_data(read_data1)
    );
    reg_bank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
        .regs(regs), .read_reg(read_reg2), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data), .read_data(read_data2)
    );
endmodule

// File: tb/tb_reg_bank_rw.sv
// tb_reg_bank_rw: randomized check of reg_bank_rw against an array model plus directed literals
module tb_reg_bank_rw;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_write = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic [4:0]  read_reg1 = '0;
    logic [4:0]  read_reg2 = '0;
    logic [31:0] read_data1, read_data2;
    logic        write_done;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m [32];
    logic        exp_done = 1'b0;
    bit          have_reset = 1'b0;

    reg_bank_rw dut (
        .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2), .write_done(write_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (reg_write && write_reg == r) return write_data;
        return m[r];
    endfunction

    // Reference model: storage as a plain array updated from the rules at each edge
    always @(posedge clk) begin
        if (reset) begin
            foreach (m[i]) m[i] = 32'd0;
            m[29] = 32'd227;
            exp_done = 1'b0;
            have_reset = 1'b1;
        end else begin
            if (reg_write && write_reg != 0) m[write_reg] = write_data;
            exp_done = reg_write && write_reg != 0;
        end
    end

    always @(negedge clk) begin
        if (have_reset) begin
            chk("read_data1", read_data1, model_read(read_reg1));
            chk("read_data2", read_data2, model_read(read_reg2));
            chk("write_done", {31'd0, write_done}, {31'd0, exp_done});
        end
    end

    task automatic drive(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        reg_write = rw; write_reg = wr; write_data = wd; read_reg1 = r1; read_reg2 = r2;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        drive(0, 0, 0, 29, 5);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("lit_sp_reset", read_data1, 32'd227);
        chk("lit_r5_reset", read_data2, 32'd0);
        chk("lit_done_reset", {31'd0, write_done}, 32'd0);

        drive(1, 8, 32'hDEADBEEF, 8, 0);
        @(negedge clk);
        chk("lit_bypass_r8", read_data1, 32'hDEADBEEF);
        step();
        drive(0, 0, 0, 8, 0);
        @(negedge clk);
        chk("lit_r8", read_data1, 32'hDEADBEEF);
        chk("lit_done_pulse", {31'd0, write_done}, 32'd1);
        step();
        @(negedge clk);
        chk("lit_done_drop", {31'd0, write_done}, 32'd0);

        drive(1, 0, 32'h12345678, 0, 0);
        @(negedge clk);
        chk("lit_r0_before", read_data2, 32'd0);
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit_r0_after", read_data2, 32'd0);
        chk("lit_r0_no_done", {31'd0, write_done}, 32'd0);

        drive(1, 31, 32'h10, 0, 0);
        step();
        drive(1, 31, 32'h400, 31, 31);
        @(negedge clk);
        chk("lit_bypass1", read_data1, 32'h400);
        chk("lit_bypass2", read_data2, 32'h400);
        step();
        drive(0, 0, 0, 31, 31);
        @(negedge clk);
        chk("lit_ra1", read_data1, 32'h400);
        chk("lit_ra2", read_data2, 32'h400);

        reset = 1'b1;
        drive(1, 29, 32'hFFFF, 0, 0);
        step();
        reset = 1'b0;
        drive(0, 0, 0, 29, 31);
        @(negedge clk);
        chk("lit_reset_prio", read_data1, 32'd227);
        chk("lit_reset_ra", read_data2, 32'd0);
        chk("lit_reset_done", {31'd0, write_done}, 32'd0);

        for (int i = 1; i <= 3; i++) begin
            drive(1, 5'(i), 32'(i + 6), 0, 0);
            step();
            @(negedge clk);
            chk("lit_b2b_done", {31'd0, write_done}, 32'd1);
        end
        drive(0, 0, 0, 1, 2);
        @(negedge clk);
        chk("lit_b2b_r1", read_data1, 32'd7);
        chk("lit_b2b_r2", read_data2, 32'd8);
        step();
        drive(0, 0, 0, 3, 8);
        @(negedge clk);
        chk("lit_b2b_r3", read_data1, 32'd9);
        chk("lit_b2b_r8", read_data2, 32'd0);
        chk("lit_b2b_done_end", {31'd0, write_done}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            logic [4:0] wr;
            wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 2) != 0, wr,
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
                  ($urandom_range(0, 3) == 0) ? wr : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? wr : 5'($urandom));
            step();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
